// File: rtl/fft_stream_ctrl.sv
// ---------------------------------------------------------------------------
// fft_stream_ctrl
//
// Sequencing controller for a single-path (SDF) streaming FFT datapath.
// Tracks the sample slot (point index k, channel ch) of an interleaved
// multi-channel stream. It accepts samples with a valid/ready handshake and
// stalls completely when no sample is offered. A stop request takes effect at
// the next frame boundary and is followed by a fixed-length drain phase. The
// drain phase keeps k/ch running so that the SDF delay lines empty out.
//
// Slot register semantics: k_q/ch_q hold the slot most recently accepted (or
// drained). The slot being accepted in the current cycle is therefore the
// successor of k_q/ch_q, except in IDLE, where the first accept is always
// slot (0,0). All switch/twiddle decodes come from the registered k_q. They
// line up with the sample one register stage into the datapath.
//
// State table:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no stream; k = all ones, ch = 0; first accept starts a frame
//   S_RUN   | streaming; every accept advances the slot, no accept = hold
//   S_FLUSH | draining; slot advances every cycle, din_ready low
//
// Ports:
//   clk        clock
//   rst        asynchronous, active-high reset
//   din_valid  input sample valid
//   din_ready  controller accepts a sample this cycle (low only in FLUSH)
//   stop       end stream at next frame boundary (latched until honoured)
//   inv        inverse-FFT mode, sampled on the first slot of each frame
//   swro       reorder-switch control, one bit per stage
//   swpe       butterfly pair-element select
//   twid_idx   twiddle ROM index for stages 1..STAGES-1 (entry s-1)
//   ch         channel of the registered slot; 0 outside RUN
//   sof        first slot of a frame accepted this cycle
//   eof        last slot of a frame accepted this cycle
//   busy       controller is not idle
//   inv_act    mode latched for the current frame
// ---------------------------------------------------------------------------
module fft_stream_ctrl #(
  parameter int FFT_SIZE     = 16,
  parameter int NUM_CH       = 1,
  parameter int FLUSH_CYCLES = 2 * FFT_SIZE
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                din_valid,
  output logic                                                din_ready,
  input  logic                                                stop,
  input  logic                                                inv,
  output logic [$clog2(FFT_SIZE)-1:0]                         swro,
  output logic                                                swpe,
  output logic [$clog2(FFT_SIZE)-2:0][$clog2(FFT_SIZE)-2:0]   twid_idx,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]      ch,
  output logic                                                sof,
  output logic                                                eof,
  output logic                                                busy,
  output logic                                                inv_act
);

  localparam int STAGES = $clog2(FFT_SIZE);
  localparam int KW     = STAGES;
  localparam int PW     = STAGES - 1;
  localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FCW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [KW-1:0]  K_LAST    = KW'(FFT_SIZE - 1);
  localparam logic [CW-1:0]  CH_LAST   = CW'(NUM_CH - 1);
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic            stop_pend_q, stop_pend_d;
  logic            inv_act_q, inv_act_d;
  logic [FCW-1:0]  flush_cnt_q, flush_cnt_d;

  logic            accept;
  logic            ch_last;
  logic [KW-1:0]   nxt_k;
  logic [CW-1:0]   nxt_ch;
  logic [KW-1:0]   slot_k;
  logic [CW-1:0]   slot_ch;
  logic [PW-1:0]   p;

  // Slot successor: channels rotate fastest, k steps when the last channel
  // wraps. With a single channel ch_q is always 0 == CH_LAST, so k steps on
  // every advance.
  assign ch_last = (ch_q == CH_LAST);
  assign nxt_k   = ch_last ? k_q + 1'b1 : k_q;
  assign nxt_ch  = ch_last ? '0 : ch_q + 1'b1;

  // Slot taken by a sample accepted this cycle.
  assign slot_k  = (state_q == S_IDLE) ? '0 : nxt_k;
  assign slot_ch = (state_q == S_IDLE) ? '0 : nxt_ch;

  assign din_ready = (state_q != S_FLUSH);
  assign accept    = din_valid & din_ready;

  assign sof = accept & (slot_k == '0) & (slot_ch == '0);
  assign eof = accept & (slot_k == K_LAST) & (slot_ch == CH_LAST);

  assign busy    = (state_q != S_IDLE);
  assign inv_act = inv_act_q;
  assign ch      = (state_q == S_RUN) ? ch_q : '0;

  // Datapath decodes, zero latency from k_q.
  assign swpe = k_q[0];
  assign p    = k_q[STAGES-1:1];

  for (genvar i = 0; i < STAGES; i++) begin : g_swro
    assign swro[i] = ~k_q[STAGES-1-i] | k_q[0];
  end

  // Stage s steps through the twiddles 2^(s-1) times faster than stage 1.
  // Inverse mode conjugates the twiddle, i.e. negates the index mod 2^PW.
  for (genvar s = 1; s < STAGES; s++) begin : g_twid
    logic [PW-1:0] base;
    assign base          = p << (s - 1);
    assign twid_idx[s-1] = inv_act_q ? (PW'(0) - base) : base;
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    ch_d        = ch_q;
    stop_pend_d = stop_pend_q;
    inv_act_d   = inv_act_q;
    flush_cnt_d = flush_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d     = S_RUN;
          k_d         = '0;
          ch_d        = '0;
          inv_act_d   = inv;
          // A stop arriving with the very first sample still lets that
          // frame complete.
          stop_pend_d = stop;
        end
      end

      S_RUN: begin
        if (accept) begin
          k_d  = nxt_k;
          ch_d = nxt_ch;
          if (sof) begin
            inv_act_d = inv;
          end
        end
        if (eof && (stop_pend_q || stop)) begin
          state_d     = S_FLUSH;
          stop_pend_d = 1'b0;
          flush_cnt_d = '0;
        end else if (stop) begin
          stop_pend_d = 1'b1;
        end
      end

      S_FLUSH: begin
        if (flush_cnt_q == FCNT_LAST) begin
          state_d     = S_IDLE;
          k_d         = '1;
          ch_d        = '0;
          stop_pend_d = 1'b0;
          flush_cnt_d = '0;
        end else begin
          k_d         = nxt_k;
          ch_d        = nxt_ch;
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '1;
      ch_q        <= '0;
      stop_pend_q <= 1'b0;
      inv_act_q   <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      ch_q        <= ch_d;
      stop_pend_q <= stop_pend_d;
      inv_act_q   <= inv_act_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Testbench for fft_stream_ctrl: two instances (1 and 4 channels, 16 points,
// 32 drain cycles) share the same stimulus. A driver pushes the expected
// outputs computed by a slot-level reference model into one queue per
// instance, and a monitor pops and compares once per cycle.
module tb_fft_stream_ctrl;

  localparam int F  = 16;
  localparam int FL = 32;
  localparam int S  = 4;
  localparam int H  = 8;

  logic clk = 1'b0;
  logic rst, din_valid, stop, inv;
  always #5 clk = ~clk;

  logic       rdy1, swpe1, ch1, sof1, eof1, busy1, ia1;
  logic [3:0] swro1;
  logic [2:0][2:0] tw1;
  logic       rdy4, swpe4, sof4, eof4, busy4, ia4;
  logic [1:0] ch4;
  logic [3:0] swro4;
  logic [2:0][2:0] tw4;

  fft_stream_ctrl #(.FFT_SIZE(F), .NUM_CH(1), .FLUSH_CYCLES(FL)) dut1 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(rdy1),
    .stop(stop), .inv(inv), .swro(swro1), .swpe(swpe1), .twid_idx(tw1),
    .ch(ch1), .sof(sof1), .eof(eof1), .busy(busy1), .inv_act(ia1));

  fft_stream_ctrl #(.FFT_SIZE(F), .NUM_CH(4), .FLUSH_CYCLES(FL)) dut4 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(rdy4),
    .stop(stop), .inv(inv), .swro(swro4), .swpe(swpe4), .twid_idx(tw4),
    .ch(ch4), .sof(sof4), .eof(eof4), .busy(busy4), .inv_act(ia4));

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       sof;
    logic       eof;
    logic       swpe;
    logic       inv_act;
    logic [3:0] swro;
    logic [8:0] twid;
    logic [1:0] ch;
  } obs_t;

  // mode: 0 idle, 1 run, 2 flush. kk/cc: last accepted slot.
  typedef struct {
    int mode;
    int kk;
    int cc;
    int spend;
    int ia;
    int fc;
  } mst_t;

  obs_t a1, a4;
  assign a1 = {rdy1, busy1, sof1, eof1, swpe1, ia1, swro1, tw1, 1'b0, ch1};
  assign a4 = {rdy4, busy4, sof4, eof4, swpe4, ia4, swro4, tw4, ch4};

  obs_t q1[$];
  obs_t q4[$];
  mst_t m1, m4;
  int   checks = 0;
  int   errors = 0;
  int   cycn   = 0;

  function automatic mst_t m_reset();
    mst_t m;
    m.mode = 0; m.kk = F - 1; m.cc = 0; m.spend = 0; m.ia = 0; m.fc = 0;
    return m;
  endfunction

  // Linear index (k*n + ch) of the slot an accept would take now.
  function automatic int slot_of(mst_t m, int n);
    if (m.mode == 0) return 0;
    return (m.kk * n + m.cc + 1) % (F * n);
  endfunction

  function automatic obs_t m_out(mst_t m, int n, bit v);
    obs_t o;
    int   sl, p, base;
    bit   acc;
    acc       = v && (m.mode != 2);
    sl        = slot_of(m, n);
    o.ready   = (m.mode != 2);
    o.busy    = (m.mode != 0);
    o.sof     = acc && (sl == 0);
    o.eof     = acc && (sl == F * n - 1);
    o.swpe    = (m.kk % 2) == 1;
    o.inv_act = (m.ia != 0);
    for (int i = 0; i < S; i++)
      o.swro[i] = (((m.kk >> (S - 1 - i)) % 2) == 0) || ((m.kk % 2) == 1);
    p      = m.kk / 2;
    o.twid = '0;
    for (int s = 1; s < S; s++) begin
      base = (p * (1 << (s - 1))) % H;
      if (m.ia != 0) base = (H - base) % H;
      o.twid[(s-1)*3 +: 3] = 3'(base);
    end
    o.ch = (m.mode == 1) ? 2'(m.cc) : 2'd0;
    return o;
  endfunction

  function automatic mst_t m_next(mst_t m, int n, bit v, bit stp, bit iv);
    mst_t r;
    int   sl;
    bit   acc;
    r   = m;
    acc = v && (m.mode != 2);
    sl  = slot_of(m, n);
    case (m.mode)
      0: if (acc) begin
        r.mode = 1; r.kk = 0; r.cc = 0; r.ia = iv; r.spend = stp;
      end
      1: begin
        if (acc) begin
          r.kk = sl / n;
          r.cc = sl % n;
          if (sl == 0) r.ia = iv;
        end
        if (acc && (sl == F * n - 1) && (m.spend != 0 || stp)) begin
          r.mode = 2; r.spend = 0; r.fc = 0;
        end else if (stp) begin
          r.spend = 1;
        end
      end
      default: begin
        if (m.fc == FL - 1) begin
          r.mode = 0; r.kk = F - 1; r.cc = 0; r.spend = 0; r.fc = 0;
        end else begin
          sl   = (m.kk * n + m.cc + 1) % (F * n);
          r.kk = sl / n;
          r.cc = sl % n;
          r.fc = m.fc + 1;
        end
      end
    endcase
    return r;
  endfunction

  // One cycle of stimulus: inputs change on the falling edge; reset acts on
  // the model immediately, mirroring its asynchronous effect.
  task automatic cyc(input bit v, input bit stp, input bit iv, input bit r);
    @(negedge clk);
    din_valid = v;
    stop      = stp;
    inv       = iv;
    rst       = r;
    if (r) begin
      m1 = m_reset();
      m4 = m_reset();
    end
    q1.push_back(m_out(m1, 1, v));
    q4.push_back(m_out(m4, 4, v));
    if (!r) begin
      m1 = m_next(m1, 1, v, stp, iv);
      m4 = m_next(m4, 4, v, stp, iv);
    end
    cycn++;
  endtask

  // Monitor: samples between the falling and rising edges.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q1.size() > 0) begin
        e = q1.pop_front();
        checks++;
        if (a1 !== e) begin
          errors++;
          $display("FAIL ch1_outputs cycle %0d: actual %h required %h (ready,busy,sof,eof,swpe,inv_act,swro,twid,ch)",
                   cycn, a1, e);
        end
      end
      if (q4.size() > 0) begin
        e = q4.pop_front();
        checks++;
        if (a4 !== e) begin
          errors++;
          $display("FAIL ch4_outputs cycle %0d: actual %h required %h (ready,busy,sof,eof,swpe,inv_act,swro,twid,ch)",
                   cycn, a4, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; din_valid = 1'b0; stop = 1'b0; inv = 1'b0;
    m1 = m_reset();
    m4 = m_reset();

    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // Continuous stream: frames for both channel counts.
    repeat (70) cyc(1, 0, 0, 0);

    // Stall for three cycles with k=5 held.
    for (int i = 0; i < 40 && !(m1.mode == 1 && m1.kk == 5); i++) cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    repeat (20) cyc(1, 0, 0, 0);

    // Inverse frame, then forward again at the following frame start.
    for (int i = 0; i < 40 && slot_of(m1, 1) != 0; i++) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    repeat (15) cyc(1, 0, 0, 0);
    repeat (20) cyc(1, 0, 0, 0);

    // Stop at k=9: frame completes, then the drain phase.
    for (int i = 0; i < 40 && !(m1.mode == 1 && m1.kk == 9); i++) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    repeat (60) cyc(1, 0, 0, 0);

    // Reset mid-frame at k=6, then restart.
    for (int i = 0; i < 40 && !(m1.mode == 1 && m1.kk == 6); i++) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    repeat (20) cyc(1, 0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++)
      cyc(($urandom % 4) != 0, ($urandom % 50) == 0, $urandom % 2 == 1,
          ($urandom % 400) == 0);

    cyc(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #4;
    checks++;
    if ((q1.size() + q4.size()) != 0) begin
      errors++;
      $display("FAIL queue_drain: actual %0d left, required 0", q1.size() + q4.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
